// File: rtl/noc_output_arbiter.sv
// Per-output-port wormhole arbiter: round-robin pick among requesting inputs,
// locks the output to the winner until its tail flit has been pushed.
module noc_output_arbiter #(
    parameter int unsigned NUM_IN  = 5,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned OWNER_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        req_i,
    input  logic [NUM_IN-1:0]        tail_i,
    input  logic [NUM_IN*DATA_W-1:0] data_i,
    input  logic                     full_i,
    output logic [NUM_IN-1:0]        grant_o,
    output logic                     push_o,
    output logic [DATA_W-1:0]        data_o,
    output logic                     locked_o,
    output logic [OWNER_W-1:0]       owner_o,
    output logic [15:0]              pkt_count_o
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    logic [OWNER_W-1:0] r_ptr;
    logic [OWNER_W-1:0] r_owner;
    logic [CNT_W-1:0]   r_pkt_count;

    state_t             w_state_nxt;
    logic [OWNER_W-1:0] w_ptr_nxt;
    logic [OWNER_W-1:0] w_owner_nxt;
    logic [CNT_W-1:0]   w_pkt_count_nxt;

    logic               w_found;
    logic [OWNER_W-1:0] w_win;
    logic [OWNER_W-1:0] w_idx;
    int unsigned        w_sum;
    logic               w_take;
    logic [OWNER_W-1:0] w_sel;
    logic [DATA_W-1:0]  w_flit [NUM_IN];

    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_flit
            assign w_flit[g] = data_i[g*DATA_W +: DATA_W];
        end
    endgenerate

    // First requester at or after ptr, wrapping modulo NUM_IN
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        w_sum   = 0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            w_sum = 32'(r_ptr) + i;
            w_idx = (w_sum >= NUM_IN) ? OWNER_W'(w_sum - NUM_IN) : OWNER_W'(w_sum);
            if (!w_found && req_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Next-state and combinational grant/push/data
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        w_pkt_count_nxt = r_pkt_count;
        w_take          = 1'b0;
        w_sel           = '0;
        locked_o        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_sel = w_win;
                if (w_found && !full_i) begin
                    w_take = 1'b1;
                    if (tail_i[w_win]) begin
                        w_ptr_nxt       = (w_win == OWNER_W'(NUM_IN-1)) ? '0 : w_win + OWNER_W'(1);
                        w_pkt_count_nxt = r_pkt_count + CNT_W'(1);
                    end else begin
                        w_state_nxt = S_LOCKED;
                        w_owner_nxt = w_win;
                    end
                end
            end
            S_LOCKED: begin
                locked_o = 1'b1;
                w_sel    = r_owner;
                if (req_i[r_owner] && !full_i) begin
                    w_take = 1'b1;
                    if (tail_i[r_owner]) begin
                        w_state_nxt     = S_IDLE;
                        w_ptr_nxt       = (r_owner == OWNER_W'(NUM_IN-1)) ? '0 : r_owner + OWNER_W'(1);
                        w_pkt_count_nxt = r_pkt_count + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (rst) begin
            w_take   = 1'b0;
            locked_o = 1'b0;
        end

        grant_o = w_take ? (NUM_IN'(1) << w_sel) : '0;
        push_o  = w_take;
        data_o  = w_take ? w_flit[w_sel] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_pkt_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_pkt_count <= w_pkt_count_nxt;
        end
    end

    assign owner_o     = r_owner;
    assign pkt_count_o = r_pkt_count;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed vector bench for noc_output_arbiter: one record per clock cycle,
// plus a long single-flit run to exercise the packet counter wrap.
module tb_noc_output_arbiter;

    localparam int unsigned NUM_IN  = 5;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned OWNER_W = 3;
    localparam int unsigned NVEC    = 31;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_IN-1:0]        req_i;
    logic [NUM_IN-1:0]        tail_i;
    logic [NUM_IN*DATA_W-1:0] data_i;
    logic                     full_i;
    logic [NUM_IN-1:0]        grant_o;
    logic                     push_o;
    logic [DATA_W-1:0]        data_o;
    logic                     locked_o;
    logic [OWNER_W-1:0]       owner_o;
    logic [15:0]              pkt_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    noc_output_arbiter #(
        .NUM_IN (NUM_IN),
        .DATA_W (DATA_W),
        .OWNER_W(OWNER_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .tail_i     (tail_i),
        .data_i     (data_i),
        .full_i     (full_i),
        .grant_o    (grant_o),
        .push_o     (push_o),
        .data_o     (data_o),
        .locked_o   (locked_o),
        .owner_o    (owner_o),
        .pkt_count_o(pkt_count_o)
    );

    typedef struct {
        logic              rst;
        logic [NUM_IN-1:0] req;
        logic [NUM_IN-1:0] tail;
        logic              full;
        logic [15:0]       d1;
        logic [NUM_IN-1:0] grant;
        logic              locked;
        logic [2:0]        owner;
        logic [15:0]       data;
        logic [15:0]       cnt;
    } vec_t;

    vec_t vec [NVEC];

    function automatic vec_t mk(input logic r, input logic [4:0] rq, input logic [4:0] tl,
                                input logic f, input logic [15:0] d1, input logic [4:0] gr,
                                input logic lk, input logic [2:0] ow, input logic [15:0] dt,
                                input logic [15:0] ct);
        vec_t v;
        v.rst = r; v.req = rq; v.tail = tl; v.full = f; v.d1 = d1;
        v.grant = gr; v.locked = lk; v.owner = ow; v.data = dt; v.cnt = ct;
        return v;
    endfunction

    // Input k carries 16'hC000+k, except input 1 which takes the per-vector flit
    task automatic drive(input logic r, input logic [4:0] rq, input logic [4:0] tl,
                         input logic f, input logic [15:0] d1);
        rst    = r;
        req_i  = rq;
        tail_i = tl;
        full_i = f;
        for (int k = 0; k < int'(NUM_IN); k++)
            data_i[k*DATA_W +: DATA_W] = (k == 1) ? d1 : 16'hC000 + 16'(k);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    initial begin
        int n;
        n = 0;
        // reset held with all inputs requesting
        vec[n++] = mk(1, 5'b11111, 5'b00000, 0, 16'h0000, 5'b00000, 0, 0, 16'h0000, 0);
        vec[n++] = mk(1, 5'b11111, 5'b00000, 0, 16'h0000, 5'b00000, 0, 0, 16'h0000, 0);
        vec[n++] = mk(0, 5'b11111, 5'b11111, 1, 16'h0000, 5'b00000, 0, 0, 16'h0000, 0);
        // round-robin single flits 0,2,4,0,2,4
        vec[n++] = mk(0, 5'b10101, 5'b11111, 0, 16'h0000, 5'b00001, 0, 0, 16'hC000, 0);
        vec[n++] = mk(0, 5'b10101, 5'b11111, 0, 16'h0000, 5'b00100, 0, 0, 16'hC002, 1);
        vec[n++] = mk(0, 5'b10101, 5'b11111, 0, 16'h0000, 5'b10000, 0, 0, 16'hC004, 2);
        vec[n++] = mk(0, 5'b10101, 5'b11111, 0, 16'h0000, 5'b00001, 0, 0, 16'hC000, 3);
        vec[n++] = mk(0, 5'b10101, 5'b11111, 0, 16'h0000, 5'b00100, 0, 0, 16'hC002, 4);
        vec[n++] = mk(0, 5'b10101, 5'b11111, 0, 16'h0000, 5'b10000, 0, 0, 16'hC004, 5);
        // 3-flit packet from input 1 while input 3 waits
        vec[n++] = mk(0, 5'b01010, 5'b00000, 0, 16'hA001, 5'b00010, 0, 0, 16'hA001, 6);
        vec[n++] = mk(0, 5'b01010, 5'b01000, 0, 16'hA002, 5'b00010, 1, 1, 16'hA002, 6);
        vec[n++] = mk(0, 5'b01010, 5'b01010, 0, 16'hA003, 5'b00010, 1, 1, 16'hA003, 6);
        vec[n++] = mk(0, 5'b01000, 5'b01000, 0, 16'h0000, 5'b01000, 0, 0, 16'hC003, 7);
        // backpressure on the second flit for 4 cycles
        vec[n++] = mk(0, 5'b01010, 5'b01000, 0, 16'hB001, 5'b00010, 0, 0, 16'hB001, 8);
        vec[n++] = mk(0, 5'b01010, 5'b01000, 1, 16'hB002, 5'b00000, 1, 1, 16'h0000, 8);
        vec[n++] = mk(0, 5'b01010, 5'b01000, 1, 16'hB002, 5'b00000, 1, 1, 16'h0000, 8);
        vec[n++] = mk(0, 5'b01010, 5'b01000, 1, 16'hB002, 5'b00000, 1, 1, 16'h0000, 8);
        vec[n++] = mk(0, 5'b01010, 5'b01000, 1, 16'hB002, 5'b00000, 1, 1, 16'h0000, 8);
        vec[n++] = mk(0, 5'b01010, 5'b01000, 0, 16'hB002, 5'b00010, 1, 1, 16'hB002, 8);
        // owner bubble for 2 cycles, then tail collides with full
        vec[n++] = mk(0, 5'b01000, 5'b01000, 0, 16'hB003, 5'b00000, 1, 1, 16'h0000, 8);
        vec[n++] = mk(0, 5'b01000, 5'b01000, 0, 16'hB003, 5'b00000, 1, 1, 16'h0000, 8);
        vec[n++] = mk(0, 5'b01010, 5'b01010, 1, 16'hB003, 5'b00000, 1, 1, 16'h0000, 8);
        vec[n++] = mk(0, 5'b01010, 5'b01010, 0, 16'hB003, 5'b00010, 1, 1, 16'hB003, 8);
        vec[n++] = mk(0, 5'b01000, 5'b01000, 0, 16'h0000, 5'b01000, 0, 0, 16'hC003, 9);
        // tail without request is ignored
        vec[n++] = mk(0, 5'b00000, 5'b11111, 0, 16'h0000, 5'b00000, 0, 0, 16'h0000, 10);
        // lock to input 4, then reset mid-packet
        vec[n++] = mk(0, 5'b10000, 5'b00000, 0, 16'h0000, 5'b10000, 0, 0, 16'hC004, 10);
        vec[n++] = mk(0, 5'b10001, 5'b00000, 0, 16'h0000, 5'b10000, 1, 4, 16'hC004, 10);
        vec[n++] = mk(1, 5'b10001, 5'b00000, 0, 16'h0000, 5'b00000, 0, 0, 16'h0000, 10);
        // after reset ptr is 0; then ptr 4 wraps to 0
        vec[n++] = mk(0, 5'b10001, 5'b10001, 0, 16'h0000, 5'b00001, 0, 0, 16'hC000, 0);
        vec[n++] = mk(0, 5'b10001, 5'b10001, 0, 16'h0000, 5'b10000, 0, 0, 16'hC004, 1);
        vec[n++] = mk(0, 5'b10001, 5'b10001, 0, 16'h0000, 5'b00001, 0, 0, 16'hC000, 2);

        drive(1, '0, '0, 0, 16'h0000);
        @(posedge clk); #1;

        for (int i = 0; i < int'(NVEC); i++) begin
            drive(vec[i].rst, vec[i].req, vec[i].tail, vec[i].full, vec[i].d1);
            @(negedge clk);
            check("grant",  i, 32'(grant_o),     32'(vec[i].grant));
            check("push",   i, 32'(push_o),      32'(|vec[i].grant));
            check("data",   i, 32'(data_o),      32'(vec[i].data));
            check("locked", i, 32'(locked_o),    32'(vec[i].locked));
            check("count",  i, 32'(pkt_count_o), 32'(vec[i].cnt));
            if (vec[i].locked)
                check("owner", i, 32'(owner_o), 32'(vec[i].owner));
            @(posedge clk); #1;
        end

        // counter wrap: 65535 single-flit completions, then one more
        drive(1, '0, '0, 0, 16'h0000);
        @(posedge clk); #1;
        for (int i = 0; i < 65535; i++) begin
            drive(0, 5'b00001, 5'b00001, 0, 16'h0000);
            @(posedge clk); #1;
        end
        drive(0, 5'b00000, 5'b00000, 0, 16'h0000);
        @(negedge clk);
        check("count_max", 0, 32'(pkt_count_o), 32'h0000FFFF);
        @(posedge clk); #1;
        drive(0, 5'b00001, 5'b00001, 0, 16'h0000);
        @(negedge clk);
        check("grant_wrap", 0, 32'(grant_o), 32'h1);
        @(posedge clk); #1;
        drive(0, 5'b00000, 5'b00000, 0, 16'h0000);
        @(negedge clk);
        check("count_wrap", 0, 32'(pkt_count_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Per-output-port wormhole arbiter for the NOC router. Sits between the router's input ports and one output port buffer, and drives that buffer's port_en and data_i.
- Picks one requesting input port round-robin and locks the output to it until that packet's tail flit has been pushed.
- Never pushes while the downstream buffer reports full.

Parameters:
- NUM_IN, 5, number of requesting input ports (local plus N/E/S/W); legal range 2..8.
- DATA_W, 16, flit width in bits.
- OWNER_W, 3, width of the owner index; must satisfy 2**OWNER_W >= NUM_IN.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_i  in  NUM_IN  bit k high: input k presents a valid flit for this output.
- tail_i  in  NUM_IN  bit k high: input k's presented flit is the last flit of its packet.
- data_i  in  NUM_IN*DATA_W  flits, input k at bits [k*DATA_W +: DATA_W].
- full_i  in  1  downstream output buffer full.
- grant_o  out  NUM_IN  one-hot; bit k high means input k's flit is consumed this cycle.
- push_o  out  1  push to output buffer (the buffer's port_en).
- data_o  out  DATA_W  flit forwarded to the output buffer.
- locked_o  out  1  output currently held by a multi-flit packet.
- owner_o  out  OWNER_W  index of the locking input; valid only while locked_o is high.
- pkt_count_o  out  16  count of completed packets (tail flits pushed).

Behaviour:
- State: two-state FSM IDLE/LOCKED, plus registered owner, round-robin pointer ptr (0..NUM_IN-1) and pkt_count.
- Reset: while rst is high the FSM goes to IDLE; ptr, owner and pkt_count go to 0. grant_o, push_o and locked_o are forced to 0, and data_o is 0.
- Outputs are combinational from current state and inputs, so there is zero-cycle latency from req_i to grant_o/push_o. State updates at the clock edge.
- Always: push_o equals the OR of grant_o, and data_o equals data_i of the granted input (0 when nothing is granted). grant_o is never asserted while full_i is high.
- IDLE arbitration:
  - Winner w is the first k with req_i[k]=1, searching ptr, ptr+1, ... with wrap mod NUM_IN.
  - If a winner exists and full_i=0, then grant_o[w]=1.
  - If tail_i[w]=1 (single-flit packet): stay IDLE, ptr <= (w+1) mod NUM_IN, pkt_count increments.
  - Otherwise: go to LOCKED, owner <= w.
  - If no request, or full_i=1: no grant and no state change (ptr is held).
- LOCKED:
  - locked_o=1 and owner_o=owner.
  - grant_o[owner] = req_i[owner] & ~full_i. All other requests are ignored regardless of priority.
  - A granted flit with tail_i[owner]=1 returns the FSM to IDLE, sets ptr <= (owner+1) mod NUM_IN, and increments pkt_count.
  - A bubble (req_i[owner]=0) or full_i stall keeps the lock indefinitely.
- ptr wrap: ptr = NUM_IN-1 followed by a completion gives ptr 0.
- pkt_count wraps from 0xFFFF to 0x0000.
- Simultaneous events:
  - full_i rising in the same cycle as a tail: that tail is not pushed, so the FSM stays LOCKED.
  - The cycle after returning to IDLE, re-arbitration is immediate, so back-to-back packets from different inputs have no idle gap.
- Reset mid-packet: the lock is dropped, and the partially forwarded packet is the upstream/downstream reset's responsibility. There is no recovery logic.
- Illegal input: tail_i[k]=1 with req_i[k]=0 is ignored.

Test Plan:
- Reset: hold rst 2 cycles with req_i=5'b11111 and full_i=0 -> grant_o=0, push_o=0, locked_o=0, pkt_count_o=0. After release, the first grant goes to input 0.
- Round-robin single flits: req_i=5'b10101 and tail_i=5'b11111 held for 6 cycles -> grants in order 0, 2, 4, 0, 2, 4; pkt_count_o=6.
- Wormhole lock: input 1 sends a 3-flit packet (0xA001, 0xA002, 0xA003 with tail) while input 3 requests continuously -> data_o is A001, A002, A003 on 3 consecutive cycles with owner_o=1. Input 3 is granted on the 4th cycle.
- Backpressure: full_i=1 during the second flit of a locked packet for 4 cycles -> push_o=0 and grant_o=0 for those 4 cycles, locked_o stays 1. The flit is pushed on the first cycle with full_i=0.
- Bubble plus tail/full collision:
  - Owner drops req_i for 2 cycles mid-packet while others request -> no grants, lock held.
  - Tail presented in the same cycle full_i=1 -> still LOCKED; the tail is pushed and the FSM returns to IDLE the next cycle with full_i=0.
- Reset mid-packet and counter wrap:
  - Assert rst while LOCKED with owner 4 -> the next cycle is IDLE with ptr=0.
  - Preload 65535 completions then one more -> pkt_count_o=0.
